if_prefetch_queue: RTL
======================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch buffer directly upstream of the IF stage of the MIPS pipeline core.
//  Runs ahead of the core, fetching sequential words from a variable-latency instruction memory
//  over a req/ack handshake, and queues {pc, instr} pairs.
//  The IF stage pops one pair per cycle when not stalled.
//  On a taken branch/jump the queue is flushed and fetch restarts at redirect_pc.
// PARAMETERS
//  DEPTH     4             queue entries (power of 2, >=2)
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk             in   1              rising-edge clock
//  rst_n           in   1              asynchronous active-low reset
//  imem_req        out  1              fetch request to instruction memory
//  imem_addr       out  32             word-aligned fetch address
//  imem_ack        in   1              imem_rdata valid; completes the outstanding request
//  imem_rdata      in   32             fetched instruction word
//  redirect_valid  in   1              branch/jump taken: flush queue, refetch
//  redirect_pc     in   32             new fetch address (bits [1:0] ignored)
//  if_ready        in   1              IF stage accepts an entry this cycle (not stalled)
//  if_valid        out  1              queue head valid
//  if_instr        out  32             head instruction (NOP 32'h0 when !if_valid)
//  if_pc           out  32             head PC
//  fill_level      out  $clog2(DEPTH)+1  number of valid entries
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fill_level=0;
//    fetch PC fpc=RESET_PC, drop flag cleared.
//  - At most one request outstanding. Issue only when fill_level + outstanding < DEPTH.
//    imem_req and imem_addr stay stable until imem_ack. Back-to-back issue is allowed the cycle after ack.
//  - imem_ack pushes {fpc_of_request, imem_rdata}; fpc += 4 (wraps modulo 2^32).
//  - Pop occurs when if_valid && if_ready. A push and a pop in the same cycle leaves fill_level unchanged.
//  - Latency: an ack into an empty queue makes if_valid=1 on the next cycle.
//  - Redirect (highest priority):
//    - Queue cleared next cycle and if_valid=0; fpc={redirect_pc[31:2],2'b00}.
//    - Any pop in the same cycle is suppressed.
//    - A same-cycle ack is discarded.
//    - If a request is outstanding without ack, drop flag is set and that request's ack is discarded
//      (not pushed, fpc not advanced).
//    - The first redirected request issues the cycle after the stale ack.
//    - A second redirect while the drop flag is set only updates fpc.
//  - Full: no request issued; if_ready=1 with no push frees one slot, and a request may issue next cycle.
//  - Empty: if_valid=0, if_instr=0; pops ignored.
//  - imem_ack with no outstanding request is ignored (assertion in sim).
// CONFIGURATION
//  - PREFETCH_BYPASS_EN defined:
//    - Queue empty, imem_ack=1, no drop/redirect: if_valid/if_instr/if_pc come combinationally from the response.
//    - If if_ready is also 1, the word is consumed that cycle and not stored. Zero-cycle latency.
//  - Undefined: all outputs registered from the queue; 1-cycle minimum latency as above.
// STRUCTURE
//  - Shared package mips_pipe_pkg:
//    - INSTR_NOP constant.
//    - fetch_entry_t {pc[31:0], instr[31:0]}.
//    - PC_STEP=4.
//  - Sub-module pq_fifo:
//    - Synchronous DEPTH x 64 FIFO: push/pop/flush, count, full/empty.
//    - Wrap-around pointers.
//  - Request FSM, drop flag and fpc live in the top.
//  - FSM states: IDLE (no request), WAIT (request outstanding), DRAIN (waiting stale ack after redirect).
//    - IDLE->WAIT on issue; WAIT->IDLE on ack; WAIT->DRAIN on redirect without ack; DRAIN->IDLE on ack.
// TESTING
//  1. Reset then 1-cycle ack memory, if_ready=1:
//     pops PCs 0x0,0x4,0x8... in order, if_instr matches imem; fill_level<=1.
//  2. if_ready=0 for 10 cycles:
//     fill_level saturates at 4, imem_req stays 0 when full; releasing if_ready pops 4 in order,
//     fetch resumes at 0x10.
//  3. Redirect to 0x0000_0042 with 2 entries queued:
//     next cycle if_valid=0, fill_level=0; next fetch address 0x40.
//  4. Redirect while a request to 0x8 awaits a 3-cycle ack:
//     stale ack data dropped; next imem_addr is the redirect target; no 0x8 entry ever popped.
//  5. rst_n low mid-request with 2 entries queued:
//     outputs immediately at reset values; after release the first imem_addr is RESET_PC.
//  6. PREFETCH_BYPASS_EN, empty queue, ack with if_ready=1:
//     if_valid=1 same cycle, fill_level stays 0; without the macro if_valid=1 one cycle later.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: fetch entry payload, NOP encoding and PC stepping.
package mips_pipe_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int unsigned ENTRY_W   = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align an address by clearing the byte-offset bits.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Prefetch queue bus bundle: instruction-memory handshake, redirect and IF-stage side.
interface if_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             if_ready;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic [CNT_W-1:0] fill_level;

  modport slave (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc, if_ready,
    output if_valid, if_instr, if_pc, fill_level
  );

  modport master (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc, if_ready,
    input  if_valid, if_instr, if_pc, fill_level
  );

endinterface

// File: rtl/pq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush, count and wrap-around pointers.
module pq_fifo
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush dominates; a push into a full FIFO is only legal alongside a pop.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i) && !flush_i;
    do_pop   = pop_i && !empty_o && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF stage; fetches sequential words ahead of the core.
// Optional zero-latency response bypass into an empty queue: PREFETCH_BYPASS_EN.
module if_prefetch_queue
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_prefetch_queue_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      redir_pc_c;
  logic             accept_c, push_c, pop_c;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head, push_entry;

  assign redir_pc_c = align_pc(bus.redirect_pc);
  assign push_entry = '{pc: addr_q, instr: bus.imem_rdata};

  // Request FSM; DRAIN doubles as the drop flag for a stale outstanding request.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fpc_d    = fpc_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.redirect_valid) begin
          fpc_d = redir_pc_c;
        end else if (!fifo_full) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          addr_d  = fpc_q;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          fpc_d = redir_pc_c;
          if (bus.imem_ack) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (bus.imem_ack) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          fpc_d    = fpc_q + PC_STEP;
          accept_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) fpc_d = redir_pc_c;
        if (bus.imem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      fpc_q   <= fpc_d;
    end
  end

  assign pop_c = !fifo_empty && bus.if_ready && !bus.redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_c;

  // A response landing in an empty queue is presented immediately; consumed words skip storage.
  assign bypass_c = fifo_empty && accept_c;
  assign push_c   = accept_c && !(bypass_c && bus.if_ready);

  always_comb begin
    bus.if_valid = !fifo_empty || bypass_c;
    bus.if_instr = INSTR_NOP;
    bus.if_pc    = '0;
    if (!fifo_empty) begin
      bus.if_instr = fifo_head.instr;
      bus.if_pc    = fifo_head.pc;
    end else if (bypass_c) begin
      bus.if_instr = bus.imem_rdata;
      bus.if_pc    = addr_q;
    end
  end
`else
  assign push_c       = accept_c;
  assign bus.if_valid = !fifo_empty;
  assign bus.if_instr = fifo_empty ? INSTR_NOP : fifo_head.instr;
  assign bus.if_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
`endif

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.fill_level = fifo_count;

  pq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_c),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .flush_i     (bus.redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  ack_without_request : assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_ack |-> (state_q != ST_IDLE)
  );

endmodule
